// File: rtl/reg_bank_alu_seq_if.sv
// Command handshake and reg_bank read/write ports of the sequenced ALU stage.
interface reg_bank_alu_seq_if #(
  parameter int DW = 64,
  parameter int AW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [AW-1:0] cmd_rd;
  logic          cmd_cnstb;
  logic [1:0]    cmd_mask;
  logic [DW-1:0] outA;
  logic [DW-1:0] outB;
  logic [AW-1:0] seloutA;
  logic [AW-1:0] seloutB;
  logic          enrregA;
  logic          enrregB;
  logic          cnstA;
  logic          cnstB;
  logic          regwen;
  logic [DW-1:0] inA;
  logic [AW-1:0] selwreg;
  logic [1:0]    endreg;
  logic          busy;
  logic          done;
  logic          zero;

  // ALU stage side
  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_cnstb, cmd_mask, outA, outB,
    output cmd_ready, seloutA, seloutB, enrregA, enrregB, cnstA, cnstB,
           regwen, inA, selwreg, endreg, busy, done, zero
  );

  // command source / reg_bank side
  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_cnstb, cmd_mask, outA, outB,
    input  cmd_ready, seloutA, seloutB, enrregA, enrregB, cnstA, cnstB,
           regwen, inA, selwreg, endreg, busy, done, zero
  );
endinterface

// File: rtl/reg_bank_alu_seq.sv
// Sequenced execute stage around reg_bank: read two operands, compute, write back.
// IDLE -> RD -> EX -> (MUL x HW) -> WB -> IDLE. Every output is a register.
module reg_bank_alu_seq #(
  parameter int DW = 64,
  parameter int AW = 4,
  parameter int HW = DW / 2
) (
  input  logic               clock,
  input  logic               reset,
  reg_bank_alu_seq_if.slave  bus
);
  localparam int NL = DW / HW;
  localparam int CW = $clog2(HW);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MOVA = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_MUL, S_WB} state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [1:0]    mask_q;
  logic [DW-1:0] mcand_q, acc_q;
  logic [HW-1:0] mplr_q;
  logic [CW-1:0] cnt_q;

  logic          cmd_ready_q, busy_q, done_q, zero_q, regwen_q;
  logic          enrregA_q, enrregB_q, cnstB_q;
  logic [AW-1:0] seloutA_q, seloutB_q, selwreg_q;
  logic [1:0]    endreg_q;
  logic [DW-1:0] inA_q;

  logic [DW-1:0] add_w, sub_w, swap_w, alu_d, acc_d;

  // Lane-wise add/sub: each HW lane wraps on its own, nothing crosses lanes
  for (genvar g = 0; g < NL; g++) begin : g_lane
    assign add_w[g*HW +: HW] = bus.outA[g*HW +: HW] + bus.outB[g*HW +: HW];
    assign sub_w[g*HW +: HW] = bus.outA[g*HW +: HW] - bus.outB[g*HW +: HW];
  end

  assign swap_w = {bus.outA[HW-1:0], bus.outA[DW-1:HW]};

  // Single-cycle result, taken straight from reg_bank's operand registers in EX
  always_comb begin
    alu_d = '0;
    case (op_q)
      OP_ADD:  alu_d = add_w;
      OP_SUB:  alu_d = sub_w;
      OP_AND:  alu_d = bus.outA & bus.outB;
      OP_OR:   alu_d = bus.outA | bus.outB;
      OP_XOR:  alu_d = bus.outA ^ bus.outB;
      OP_MOVA: alu_d = bus.outA;
      OP_SWAP: alu_d = swap_w;
      default: alu_d = '0;
    endcase
  end

  // Shift-add step: one multiplier bit consumed per cycle
  assign acc_d = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

  // Sequencer with registered outputs; reset aborts any command without a write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      mask_q      <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      regwen_q    <= 1'b0;
      enrregA_q   <= 1'b0;
      enrregB_q   <= 1'b0;
      cnstB_q     <= 1'b0;
      seloutA_q   <= '0;
      seloutB_q   <= '0;
      selwreg_q   <= '0;
      endreg_q    <= '0;
      inA_q       <= '0;
    end else begin
      regwen_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            rd_q        <= bus.cmd_rd;
            mask_q      <= bus.cmd_mask;
            seloutA_q   <= bus.cmd_ra;
            seloutB_q   <= bus.cmd_rb;
            cnstB_q     <= bus.cmd_cnstb;
            enrregA_q   <= 1'b1;
            enrregB_q   <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_RD;
          end
        end
        S_RD: begin
          enrregA_q <= 1'b0;
          enrregB_q <= 1'b0;
          cnstB_q   <= 1'b0;
          state_q   <= S_EX;
        end
        S_EX: begin
          if (op_q == OP_MUL) begin
            mcand_q <= {{(DW-HW){1'b0}}, bus.outA[HW-1:0]};
            mplr_q  <= bus.outB[HW-1:0];
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_MUL;
          end else begin
            inA_q     <= alu_d;
            zero_q    <= (alu_d == '0);
            regwen_q  <= 1'b1;
            done_q    <= 1'b1;
            selwreg_q <= rd_q;
            endreg_q  <= mask_q;
            state_q   <= S_WB;
          end
        end
        S_MUL: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(HW-1)) begin
            inA_q     <= acc_d;
            zero_q    <= (acc_d == '0);
            regwen_q  <= 1'b1;
            done_q    <= 1'b1;
            selwreg_q <= rd_q;
            endreg_q  <= mask_q;
            state_q   <= S_WB;
          end
        end
        S_WB: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.zero      = zero_q;
  assign bus.regwen    = regwen_q;
  assign bus.enrregA   = enrregA_q;
  assign bus.enrregB   = enrregB_q;
  assign bus.cnstA     = 1'b0;
  assign bus.cnstB     = cnstB_q;
  assign bus.seloutA   = seloutA_q;
  assign bus.seloutB   = seloutB_q;
  assign bus.selwreg   = selwreg_q;
  assign bus.endreg    = endreg_q;
  assign bus.inA       = inA_q;
endmodule

// File: tb/tb_reg_bank_alu_seq.sv
// Directed bench for reg_bank_alu_seq with a small behavioural reg_bank model.
module tb_reg_bank_alu_seq;
  localparam logic [63:0] CNST = 64'h00000010_00000020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_alu_seq_if #(.DW(64), .AW(4)) bus();

  reg_bank_alu_seq #(.DW(64), .AW(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [63:0] regs [16];
  int          cyc = 0;
  int          acc_cnt = 0, acc_edge = 0;
  int          wr_cnt = 0, wr_edge = 0;
  logic [63:0] last_data;
  logic [3:0]  last_idx;
  logic [1:0]  last_mode;
  logic        last_done, last_zero;
  int          nchk = 0, npass = 0;

  // reg_bank model: registered read ports, field-masked write port, write log
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      regs[1]  <= 64'h00000000_0000FFFF;
      regs[2]  <= 64'h00000001_FFFFFFFF;
      regs[3]  <= 64'h00000001_00000001;
      regs[5]  <= 64'h12345678_9ABCDEF0;
      regs[6]  <= 64'h12345678_9ABCDEF0;
      regs[8]  <= 64'hAAAAAAAA_55555555;
      regs[11] <= 64'hDEAD0000_0000FFFF;
      regs[12] <= 64'hBEEF0000_00010001;
      regs[14] <= 64'h00000000_00000001;
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_edge <= cyc;
    end
    if (bus.enrregA) bus.outA <= bus.cnstA ? CNST : regs[bus.seloutA];
    if (bus.enrregB) bus.outB <= bus.cnstB ? CNST : regs[bus.seloutB];
    if (bus.regwen) begin
      case (bus.endreg)
        2'b10:   regs[bus.selwreg][63:32] <= bus.inA[63:32];
        2'b01:   regs[bus.selwreg][31:0]  <= bus.inA[31:0];
        default: regs[bus.selwreg]        <= bus.inA;
      endcase
      wr_cnt    <= wr_cnt + 1;
      wr_edge   <= cyc;
      last_data <= bus.inA;
      last_idx  <= bus.selwreg;
      last_mode <= bus.endreg;
      last_done <= bus.done;
      last_zero <= bus.zero;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_timeout", 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rd, input logic cb, input logic [1:0] mk);
    bus.cmd_op = op; bus.cmd_ra = ra; bus.cmd_rb = rb;
    bus.cmd_rd = rd; bus.cmd_cnstb = cb; bus.cmd_mask = mk;
  endtask

  // Issue one command, wait for its write, check data, routing and latency
  task automatic run(input string tag, input logic [2:0] op, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [3:0] rd, input logic cb,
                     input logic [1:0] mk, input logic [63:0] exp_d, input int lat);
    int w0 = wr_cnt;
    int n = 0;
    wait_ready();
    drive(op, ra, rb, rd, cb, mk);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b11);
    while (wr_cnt == w0 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_wrcnt"}, 64'(wr_cnt - w0), 64'd1);
    chk({tag, "_data"},  last_data, exp_d);
    chk({tag, "_lat"},   64'(wr_edge - acc_edge), 64'(lat));
    chk({tag, "_rd"},    64'(last_idx), 64'(rd));
    chk({tag, "_mode"},  64'(last_mode), 64'(mk));
    chk({tag, "_done"},  64'(last_done), 64'd1);
    chk({tag, "_zero"},  64'(last_zero), 64'(exp_d == 64'd0));
  endtask

  initial begin
    int w0, a0, ae1, n;
    bus.cmd_valid = 1'b0;
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    chk("rst_ready",  64'(bus.cmd_ready), 64'd1);
    chk("rst_busy",   64'(bus.busy),      64'd0);
    chk("rst_regwen", 64'(bus.regwen),    64'd0);
    chk("rst_done",   64'(bus.done),      64'd0);
    chk("rst_zero",   64'(bus.zero),      64'd0);
    chk("rst_inA",    bus.inA,            64'd0);
    rst = 1'b0;
    @(negedge clk);

    run("add",    3'b000, 4'd2,  4'd3,  4'd4,  1'b0, 2'b00, 64'h00000002_00000000, 3);
    chk("add_r4", regs[4], 64'h00000002_00000000);
    run("sub",    3'b001, 4'd5,  4'd6,  4'd7,  1'b0, 2'b00, 64'h0, 3);
    run("borrow", 3'b001, 4'd13, 4'd14, 4'd13, 1'b0, 2'b00, 64'h00000000_FFFFFFFF, 3);
    run("and",    3'b010, 4'd8,  4'd3,  4'd10, 1'b0, 2'b00, 64'h00000000_00000001, 3);
    run("or",     3'b011, 4'd8,  4'd3,  4'd10, 1'b0, 2'b00, 64'hAAAAAAAB_55555555, 3);
    run("xor",    3'b100, 4'd8,  4'd3,  4'd10, 1'b0, 2'b00, 64'hAAAAAAAB_55555554, 3);
    run("cnst",   3'b000, 4'd3,  4'd0,  4'd10, 1'b1, 2'b00, 64'h00000011_00000021, 3);
    run("mul",    3'b111, 4'd11, 4'd12, 4'd15, 1'b0, 2'b00, 64'h00000000_FFFFFFFF, 35);
    run("mulmax", 3'b111, 4'd2,  4'd2,  4'd15, 1'b0, 2'b00, 64'hFFFFFFFE_00000001, 35);
    run("swap",   3'b110, 4'd8,  4'd0,  4'd9,  1'b0, 2'b10, 64'h55555555_AAAAAAAA, 3);
    run("mova",   3'b101, 4'd9,  4'd0,  4'd10, 1'b0, 2'b00, 64'h55555555_00000000, 3);

    // valid held across two different commands
    wait_ready();
    w0 = wr_cnt; a0 = acc_cnt;
    drive(3'b000, 4'd2, 4'd3, 4'd0, 1'b0, 2'b00);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    ae1 = acc_edge;
    drive(3'b100, 4'd8, 4'd3, 4'd6, 1'b0, 2'b00);
    n = 0;
    while (acc_cnt < a0 + 2 && n < 20) begin @(negedge clk); n++; end
    bus.cmd_valid = 1'b0;
    chk("hs_gap", 64'(acc_edge - ae1), 64'd4);
    n = 0;
    while (wr_cnt < w0 + 2 && n < 40) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    chk("hs_wrcnt", 64'(wr_cnt - w0), 64'd2);
    chk("hs_acc",   64'(acc_cnt - a0), 64'd2);
    chk("hs_r0",    regs[0], 64'h00000002_00000000);
    chk("hs_r6",    regs[6], 64'hAAAAAAAB_55555554);

    // reset in the middle of a multiply
    run("subz", 3'b001, 4'd5, 4'd5, 4'd7, 1'b0, 2'b00, 64'h0, 3);
    wait_ready();
    w0 = wr_cnt;
    drive(3'b111, 4'd11, 4'd12, 4'd4, 1'b0, 2'b00);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (11) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ar_busy",   64'(bus.busy),      64'd0);
    chk("ar_ready",  64'(bus.cmd_ready), 64'd1);
    chk("ar_regwen", 64'(bus.regwen),    64'd0);
    chk("ar_zero",   64'(bus.zero),      64'd0);
    chk("ar_inA",    bus.inA,            64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("ar_nowr",   64'(wr_cnt - w0),   64'd0);
    chk("ar_ready2", 64'(bus.cmd_ready), 64'd1);
    chk("ar_r4",     regs[4], 64'h00000002_00000000);
    run("post", 3'b000, 4'd2, 4'd3, 4'd5, 1'b0, 2'b00, 64'h00000002_00000000, 3);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
